// File: rtl/alu_issue_arbiter.sv
// ============================================================================
// Module   : alu_issue_arbiter (with local alu)
// Brief    : Round-robin arbiter sharing one RV64 alu between two requesters
//            and registering the result in a single-entry output stage.
//            Optional macro ALU_ARB_OPCNT_EN adds per-requester op counters.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [5:0]      shamt,
  input  logic [2:0]      func3,
  input  logic [6:0]      func7,
  output logic [XLEN-1:0] result,
  output logic            comparison
);
  logic alt;
  logic lt_s;
  logic lt_u;

  always_comb begin
    alt  = (func7 == 7'b0100000);
    lt_s = $signed(a) < $signed(b);
    lt_u = a < b;
    result = '0;
    case (func3)
      3'b000: result = alt ? (a - b) : (a + b);
      3'b001: result = a << shamt;
      3'b010: result = {{(XLEN-1){1'b0}}, lt_s};
      3'b011: result = {{(XLEN-1){1'b0}}, lt_u};
      3'b100: result = a ^ b;
      3'b101: result = alt ? XLEN'($signed(a) >>> shamt) : (a >> shamt);
      3'b110: result = a | b;
      default: result = a & b;
    endcase
    // Set-less-than ops report the ordering; every other op reports equality.
    case (func3)
      3'b010:  comparison = lt_s;
      3'b011:  comparison = lt_u;
      default: comparison = (a == b);
    endcase
  end
endmodule

module alu_issue_arbiter #(
  parameter int XLEN = 64,
  parameter int ID_W = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic [5:0]      req0_shamt,
  input  logic [2:0]      req0_func3,
  input  logic [6:0]      req0_func7,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  input  logic [5:0]      req1_shamt,
  input  logic [2:0]      req1_func3,
  input  logic [6:0]      req1_func7,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [ID_W-1:0] rsp_id,
  output logic [XLEN-1:0] rsp_result,
  output logic            rsp_cmp
`ifdef ALU_ARB_OPCNT_EN
  ,
  output logic [31:0]     op_cnt0,
  output logic [31:0]     op_cnt1
`endif
);
  typedef enum logic [0:0] {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  state_t          state_q, state_d;
  logic            rr_ptr_q, rr_ptr_d;
  logic [XLEN-1:0] rsp_result_q, rsp_result_d;
  logic            rsp_cmp_q, rsp_cmp_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;

  logic            can_accept;
  logic [1:0]      grant;
  logic            sel;
  logic [XLEN-1:0] alu_a, alu_b, alu_result;
  logic [5:0]      alu_shamt;
  logic [2:0]      alu_func3;
  logic [6:0]      alu_func7;
  logic            alu_cmp;

`ifdef ALU_ARB_OPCNT_EN
  logic [31:0] op_cnt0_q, op_cnt0_d;
  logic [31:0] op_cnt1_q, op_cnt1_d;
`endif

  alu #(.XLEN(XLEN)) u_alu (
    .a          (alu_a),
    .b          (alu_b),
    .shamt      (alu_shamt),
    .func3      (alu_func3),
    .func7      (alu_func7),
    .result     (alu_result),
    .comparison (alu_cmp)
  );

  always_comb begin
    can_accept = (state_q == S_EMPTY) || rsp_ready;
    grant = 2'b00;
    if (can_accept) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = rr_ptr_q ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
    sel = grant[1];

    alu_a     = sel ? req1_a     : req0_a;
    alu_b     = sel ? req1_b     : req0_b;
    alu_shamt = sel ? req1_shamt : req0_shamt;
    alu_func3 = sel ? req1_func3 : req0_func3;
    alu_func7 = sel ? req1_func7 : req0_func7;

    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    rsp_result_d = rsp_result_q;
    rsp_cmp_d    = rsp_cmp_q;
    rsp_id_d     = rsp_id_q;
    if (grant != 2'b00) begin
      state_d      = S_FULL;
      rr_ptr_d     = ~sel;
      rsp_result_d = alu_result;
      rsp_cmp_d    = alu_cmp;
      rsp_id_d     = ID_W'(sel);
    end else if (rsp_ready) begin
      // Retire only; data registers keep their last contents.
      state_d = S_EMPTY;
    end

`ifdef ALU_ARB_OPCNT_EN
    op_cnt0_d = op_cnt0_q + {31'd0, grant[0]};
    op_cnt1_d = op_cnt1_q + {31'd0, grant[1]};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_EMPTY;
      rr_ptr_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_cmp_q    <= 1'b0;
      rsp_id_q     <= '0;
`ifdef ALU_ARB_OPCNT_EN
      op_cnt0_q    <= '0;
      op_cnt1_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      rsp_result_q <= rsp_result_d;
      rsp_cmp_q    <= rsp_cmp_d;
      rsp_id_q     <= rsp_id_d;
`ifdef ALU_ARB_OPCNT_EN
      op_cnt0_q    <= op_cnt0_d;
      op_cnt1_q    <= op_cnt1_d;
`endif
    end
  end

  assign req_ready  = grant;
  assign rsp_valid  = (state_q == S_FULL);
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_cmp    = rsp_cmp_q;
`ifdef ALU_ARB_OPCNT_EN
  assign op_cnt0 = op_cnt0_q;
  assign op_cnt1 = op_cnt1_q;
`endif

endmodule

`default_nettype wire

// File: doc/alu_issue_arbiter.md
Name: alu_issue_arbiter

Overview:
- Shares one instance of the team's 64-bit RV64 `alu` between two requesters, e.g. the integer issue slot and the address/branch-compare unit.
- Requests are arbitrated round-robin with a valid/ready handshake, executed on the combinational ALU, and registered into a single-entry output stage.
- The output stage carries the result, the comparison flag, and a requester ID tag.

Parameters:
- XLEN, 64, operand/result width; must match the alu datapath (only 64 supported).
- ID_W, 1, width of the response ID tag; requester i is tagged i.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req_valid  input  2  per-requester request valid; bit i = requester i
- req_ready  output  2  per-requester grant/accept; a transfer occurs when valid&ready
- req0_a, req0_b  input  XLEN each  requester 0 operands
- req0_shamt  input  6  requester 0 shift amount
- req0_func3  input  3  requester 0 func3
- req0_func7  input  7  requester 0 func7
- req1_a, req1_b, req1_shamt, req1_func3, req1_func7  input  as above  requester 1 fields
- rsp_valid  output  1  output register holds a valid response
- rsp_ready  input  1  consumer accepts the response
- rsp_id  output  ID_W  requester that issued the response
- rsp_result  output  XLEN  registered alu Result
- rsp_cmp  output  1  registered alu Comparison

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): rsp_valid=0, rsp_id=0, rsp_result=0, rsp_cmp=0, rr_ptr=0 (requester 0 has priority). Any held response is dropped. Reset applies mid-operation identically.
- State machine, two states:
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
- can_accept = EMPTY | (FULL & rsp_ready). This gives pipelined back-to-back throughput of 1 op/cycle.
- Grant is combinational:
  - if can_accept and exactly one req_valid bit is set, grant that requester;
  - if both are set, grant requester rr_ptr.
  - req_ready[i] = grant[i]. req_ready is never asserted while FULL & !rsp_ready.
- On a transfer (any grant):
  - the selected operands drive the single alu instance (mux before alu);
  - on the next edge, rsp_result/rsp_cmp/rsp_id load and the state goes to FULL;
  - rr_ptr <= ~granted index (the other requester gets priority next).
- No grant and FULL & rsp_ready: go to EMPTY, rsp_valid=0. Data registers hold their last values.
- FULL & !rsp_ready: all rsp_* outputs are held stable (no change until accepted).
- Latency: response visible exactly 1 cycle after the accepting edge.
- Simultaneous rsp_ready and a new grant: the old response retires and the new one loads on the same edge; rsp_valid stays 1.
- Requester inputs are sampled only in the cycle of the transfer. A requester may drop valid without a transfer; there is no ordering requirement.
- rr_ptr changes only on a contention-free or contended grant. It does not change when there is no grant.
- Operation encoding is passed unmodified to the alu (func3/func7/shamt semantics are owned by alu).

Optional Feature:
- Macro ALU_ARB_OPCNT_EN.
- When defined, adds output ports op_cnt0 and op_cnt1 (32 bits each):
  - each counts completed requester transfers;
  - reset to 0 by rst;
  - wrap from 0xFFFFFFFF to 0;
  - increment on the same edge as the response load.
- When undefined, the ports and counters do not exist and the behaviour is otherwise identical.

Test Plan:
- Reset then idle.
  - Stimulus: rst=1 for 2 cycles, then req_valid=00.
  - Response: rsp_valid=0, req_ready=00, rsp_result=0.
- Single ADD from requester 1.
  - Stimulus: a=5, b=3, func3=000, func7=0000000, rsp_ready=1.
  - Response: req_ready=10 in cycle N; rsp_valid=1, rsp_id=1, rsp_result=8 at N+1.
- Contention.
  - Stimulus: both valid every cycle, rsp_ready=1. Req0 SUB a=5,b=3; req1 XOR a=123456789ABCDEF0, b=FEDCBA9876543210.
  - Response: grants alternate 0,1,0,1. Results alternate 2 and ECE8ECE0ECE8ECE0, with the id tag matching.
- Backpressure.
  - Stimulus: rsp_ready=0 after the first SRA (a=F000000000000000, shamt=4, func7=0100000) is accepted.
  - Response: rsp_result=FF00000000000000 held; req_ready=00 for 5 cycles.
  - Then rsp_ready=1: the pending request is accepted the same cycle and the next response follows on the next edge.
- SLTU compare.
  - Stimulus: a=FFFFFFFFFFFFFFFF, b=1, func3=011.
  - Response: rsp_cmp=0. With a and b swapped, rsp_cmp=1.
- Reset mid-stream and counter wrap.
  - Stimulus: rst while FULL.
  - Response: rsp_valid=0 next cycle, rr_ptr=0.
  - With ALU_ARB_OPCNT_EN, a counter forced to FFFFFFFF wraps to 0 on the next transfer.
